spi_controller: RTL and testbench

SPI_CONTROLLER -- requirements
Module: spi_controller

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_controller_if.sv | 40 ++++
 rtl/spi_clk_tick.sv | 26 ++
 rtl/spi_controller.sv | 162 ++++++++++++++++
 tb/tb_spi_controller.sv | 241 ++++++++++++++++++++++++
 5 files changed

// File: rtl/spi_pkg.sv
// Shared types and constants for the SPI controller.
// SPI_CTRL_BYTE_GAP_EN adds the StByteGap state to the state enumeration.
package spi_pkg;

    localparam int unsigned ByteWidth = 8;
    localparam int unsigned MinClkDiv = 4;

    typedef enum logic [2:0] {
        StIdle,
        StLead,
        StSckHi,
        StSckLo,
        StTrail,
        StCsGap
`ifdef SPI_CTRL_BYTE_GAP_EN
        ,
        StByteGap
`endif
    } state_e;

endpackage

// File: rtl/spi_controller_if.sv
// Host-side request/response and SPI pin bundle for spi_controller.
// The master modport is the controller itself; slave is whoever drives it and
// models the peripheral.
interface spi_controller_if #(
    parameter int unsigned BITS = 64
);
    logic            start;
    logic [BITS-1:0] tx_word;
    logic            busy;
    logic            done;
    logic [BITS-1:0] rx_word;
    logic            SCK;
    logic            CS;
    logic            COPI;
    logic            CIPO;

    modport master (
        input  start,
        input  tx_word,
        input  CIPO,
        output busy,
        output done,
        output rx_word,
        output SCK,
        output CS,
        output COPI
    );

    modport slave (
        output start,
        output tx_word,
        output CIPO,
        input  busy,
        input  done,
        input  rx_word,
        input  SCK,
        input  CS,
        input  COPI
    );
endinterface

// File: rtl/spi_clk_tick.sv
// Half-period tick generator: pulses when the count reaches CLK_DIV-1.
// Held at zero while clear is high so every phase starts a full half-period;
// the tick itself wraps the count, which is when the FSM changes state.
module spi_clk_tick #(
    parameter int unsigned CLK_DIV = 4
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    output logic tick
);
    localparam int unsigned CntW = $clog2(CLK_DIV);

    logic [CntW-1:0] cnt_q;

    assign tick = (cnt_q == CntW'(CLK_DIV - 1)) && !clear;

    // Free-running half-period counter, restarted on clear or tick.
    always_ff @(posedge clk) begin
        if (!resetn || clear || tick) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_q + CntW'(1);
        end
    end
endmodule

// File: rtl/spi_controller.sv
// SPI mode-0 controller: little-endian byte order, MSB first within a byte.
// Define SPI_CTRL_BYTE_GAP_EN to insert a 2*CLK_DIV SCK-low gap between bytes.
import spi_pkg::*;

module spi_controller #(
    parameter int unsigned BITS    = 64,
    parameter int unsigned CLK_DIV = 4
) (
    input  logic             clk,
    input  logic             resetn,
    spi_controller_if.master bus
);
    localparam int unsigned CntW = $clog2(BITS);

    if (CLK_DIV < MinClkDiv) begin : g_bad_div
        $error("spi_controller: CLK_DIV below minimum");
    end
    if (BITS != 32 && BITS != 64) begin : g_bad_bits
        $error("spi_controller: BITS must be 32 or 64");
    end

    state_e          state_q;
    logic [BITS-1:0] tx_q;
    logic [BITS-1:0] rx_sr_q;
    logic [BITS-1:0] rx_word_q;
    logic [CntW-1:0] bit_cnt_q;
    logic            sck_q;
    logic            cs_q;
    logic            copi_q;
    logic            busy_q;
    logic            done_q;
    logic            tick;
    logic            tick_clear;
    logic            last_bit;
`ifdef SPI_CTRL_BYTE_GAP_EN
    logic            gap_half_q;
    logic            byte_end;
`endif

    // Transfer-order bit n maps to word bit {byte, 7 - bit-in-byte}.
    function automatic logic [CntW-1:0] bit_index(input logic [CntW-1:0] n);
        return {n[CntW-1:3], ~n[2:0]};
    endfunction

    assign tick_clear = (state_q == StIdle);
    assign last_bit   = (bit_cnt_q == CntW'(BITS - 1));
`ifdef SPI_CTRL_BYTE_GAP_EN
    assign byte_end   = (bit_cnt_q[2:0] == 3'(ByteWidth - 1));
`endif

    spi_clk_tick #(
        .CLK_DIV(CLK_DIV)
    ) u_tick (
        .clk   (clk),
        .resetn(resetn),
        .clear (tick_clear),
        .tick  (tick)
    );

    // Transfer sequencer; all pin and status outputs are registered here.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            state_q   <= StIdle;
            tx_q      <= '0;
            rx_sr_q   <= '0;
            rx_word_q <= '0;
            bit_cnt_q <= '0;
            sck_q     <= 1'b0;
            cs_q      <= 1'b1;
            copi_q    <= 1'b0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef SPI_CTRL_BYTE_GAP_EN
            gap_half_q <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (bus.start) begin
                        tx_q    <= bus.tx_word;
                        state_q <= StLead;
                        busy_q  <= 1'b1;
                        cs_q    <= 1'b0;
                        copi_q  <= bus.tx_word[7];
                    end
                end
                StLead: begin
                    if (tick) begin
                        state_q <= StSckHi;
                        sck_q   <= 1'b1;
                        rx_sr_q[bit_index(bit_cnt_q)] <= bus.CIPO;
                    end
                end
                StSckHi: begin
                    if (tick) begin
                        state_q <= StSckLo;
                        sck_q   <= 1'b0;
                        // Last bit stays on COPI through TRAIL.
                        if (!last_bit) begin
                            copi_q <= tx_q[bit_index(bit_cnt_q + CntW'(1))];
                        end
                    end
                end
                StSckLo: begin
                    if (tick) begin
                        bit_cnt_q <= bit_cnt_q + CntW'(1);
                        if (last_bit) begin
                            state_q <= StTrail;
`ifdef SPI_CTRL_BYTE_GAP_EN
                        end else if (byte_end) begin
                            state_q <= StByteGap;
`endif
                        end else begin
                            state_q <= StSckHi;
                            sck_q   <= 1'b1;
                            rx_sr_q[bit_index(bit_cnt_q + CntW'(1))] <= bus.CIPO;
                        end
                    end
                end
`ifdef SPI_CTRL_BYTE_GAP_EN
                // Two half-periods with SCK low; COPI already holds the next MSB.
                StByteGap: begin
                    if (tick) begin
                        gap_half_q <= ~gap_half_q;
                        if (gap_half_q) begin
                            state_q <= StSckHi;
                            sck_q   <= 1'b1;
                            rx_sr_q[bit_index(bit_cnt_q)] <= bus.CIPO;
                        end
                    end
                end
`endif
                StTrail: begin
                    if (tick) begin
                        state_q   <= StCsGap;
                        cs_q      <= 1'b1;
                        copi_q    <= 1'b0;
                        rx_word_q <= rx_sr_q;
                        done_q    <= 1'b1;
                    end
                end
                StCsGap: begin
                    if (tick) begin
                        state_q <= StIdle;
                        busy_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign bus.SCK     = sck_q;
    assign bus.CS      = cs_q;
    assign bus.COPI    = copi_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;
    assign bus.rx_word = rx_word_q;
endmodule

// File: tb/tb_spi_controller.sv
// Directed bench for spi_controller: a 64-bit instance with an 8-bit mode-0
// peripheral returning 8'hA5 per byte, and a 32-bit instance with CIPO looped
// back from COPI. Expectations follow SPI_CTRL_BYTE_GAP_EN when it is defined.
module tb_spi_controller;
    localparam int ClkDiv = 4;
`ifdef SPI_CTRL_BYTE_GAP_EN
    localparam int GapExtra64 = 7 * 2 * ClkDiv;
    localparam int GapExtra32 = 3 * 2 * ClkDiv;
    localparam int LongRuns32 = 3;
    localparam int MaxRun32   = 3 * ClkDiv;
`else
    localparam int GapExtra64 = 0;
    localparam int GapExtra32 = 0;
    localparam int LongRuns32 = 0;
    localparam int MaxRun32   = ClkDiv;
`endif
    localparam int Lat64 = (2 * 64 + 2) * ClkDiv + 1 + GapExtra64;
    localparam int Lat32 = (2 * 32 + 2) * ClkDiv + 1 + GapExtra32;

    logic clk = 1'b0;
    logic resetn64;
    logic resetn32;
    int   checks = 0;
    int   fails  = 0;
    int   viol   = 0;

    always #5 clk = ~clk;

    spi_controller_if #(.BITS(64)) if64 ();
    spi_controller_if #(.BITS(32)) if32 ();

    spi_controller #(
        .BITS   (64),
        .CLK_DIV(ClkDiv)
    ) u_dut64 (
        .clk   (clk),
        .resetn(resetn64),
        .bus   (if64.master)
    );

    spi_controller #(
        .BITS   (32),
        .CLK_DIV(ClkDiv)
    ) u_dut32 (
        .clk   (clk),
        .resetn(resetn32),
        .bus   (if32.master)
    );

    // Mode-0 peripheral: MSB out on CS fall, next bit after each SCK fall.
    logic [7:0] per_pattern = 8'hA5;
    logic [2:0] per_ptr     = 3'd0;
    logic       per_sck_q   = 1'b0;
    assign if64.CIPO = per_pattern[3'd7 - per_ptr];
    always @(negedge clk) begin
        if (if64.CS === 1'b1) per_ptr = 3'd0;
        else if (per_sck_q && !if64.SCK) per_ptr = per_ptr + 3'd1;
        per_sck_q = if64.SCK;
    end

    assign if32.CIPO = if32.COPI;

    // Pin protocol monitors: COPI stable while SCK high, SCK low while CS high.
    logic sck64_m = 1'b0, copi64_m = 1'b0, sck32_m = 1'b0, copi32_m = 1'b0;
    always @(negedge clk) begin
        assert (!(sck64_m && if64.SCK && (copi64_m !== if64.COPI))) else viol++;
        assert (!(if64.SCK === 1'b1 && if64.CS === 1'b1)) else viol++;
        assert (!(sck32_m && if32.SCK && (copi32_m !== if32.COPI))) else viol++;
        assert (!(if32.SCK === 1'b1 && if32.CS === 1'b1)) else viol++;
        sck64_m  = if64.SCK;
        copi64_m = if64.COPI;
        sck32_m  = if32.SCK;
        copi32_m = if32.COPI;
    end

    task automatic wait_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        resetn64 = 1'b0;
        resetn32 = 1'b0;
        if64.start = 1'b0;
        if64.tx_word = '0;
        if32.start = 1'b0;
        if32.tx_word = '0;
        repeat (3) wait_cycle();
        checks++; if (if64.SCK !== 1'b0) begin fails++; $display("FAIL reset_sck got %b exp 0", if64.SCK); end
        checks++; if (if64.CS !== 1'b1) begin fails++; $display("FAIL reset_cs got %b exp 1", if64.CS); end
        checks++; if (if64.COPI !== 1'b0) begin fails++; $display("FAIL reset_copi got %b exp 0", if64.COPI); end
        checks++; if (if64.busy !== 1'b0) begin fails++; $display("FAIL reset_busy got %b exp 0", if64.busy); end
        checks++; if (if64.done !== 1'b0) begin fails++; $display("FAIL reset_done got %b exp 0", if64.done); end
        checks++; if (if64.rx_word !== 64'h0) begin fails++; $display("FAIL reset_rx64 got %h exp 0", if64.rx_word); end
        checks++; if (if32.CS !== 1'b1) begin fails++; $display("FAIL reset_cs32 got %b exp 1", if32.CS); end
        checks++; if (if32.rx_word !== 32'h0) begin fails++; $display("FAIL reset_rx32 got %h exp 0", if32.rx_word); end
        resetn64 = 1'b1;
        resetn32 = 1'b1;
        wait_cycle();
    endtask

    task automatic test_transfer64();
        logic [63:0] tx;
        logic [63:0] stream;
        logic [7:0]  b;
        logic        prev;
        int          cyc, rises, done_cnt, done_at;
        tx = 64'h0807060504030201;
        if64.tx_word = tx;
        if64.start = 1'b1;
        wait_cycle();
        cyc = 1;
        if64.start = 1'b0;
        checks++; if (if64.busy !== 1'b1) begin fails++; $display("FAIL t64_busy got %b exp 1", if64.busy); end
        checks++; if (if64.CS !== 1'b0) begin fails++; $display("FAIL t64_cs got %b exp 0", if64.CS); end
        checks++; if (if64.COPI !== tx[7]) begin fails++; $display("FAIL t64_copi0 got %b exp %b", if64.COPI, tx[7]); end
        rises = 0; done_cnt = 0; done_at = 0; prev = 1'b0; stream = '0;
        while (cyc < Lat64 + 150) begin
            if (if64.SCK && !prev) begin
                if (rises < 64) stream[rises] = if64.COPI;
                rises++;
            end
            prev = if64.SCK;
            if (if64.done) begin
                done_cnt++;
                if (done_cnt == 1) done_at = cyc;
            end
            wait_cycle();
            cyc++;
        end
        checks++; if (done_cnt !== 1) begin fails++; $display("FAIL t64_done_count got %0d exp 1", done_cnt); end
        checks++; if (done_at !== Lat64) begin fails++; $display("FAIL t64_latency got %0d exp %0d", done_at, Lat64); end
        checks++; if (rises !== 64) begin fails++; $display("FAIL t64_sck_rises got %0d exp 64", rises); end
        checks++; if (if64.rx_word !== {8{8'hA5}}) begin fails++; $display("FAIL t64_rx got %h exp %h", if64.rx_word, {8{8'hA5}}); end
        checks++; if (if64.busy !== 1'b0) begin fails++; $display("FAIL t64_busy_end got %b exp 0", if64.busy); end
        for (int k = 0; k < 8; k++) begin
            for (int j = 0; j < 8; j++) b[7 - j] = stream[8 * k + j];
            checks++;
            if (b !== 8'(k + 1)) begin fails++; $display("FAIL t64_copi_byte%0d got %h exp %h", k, b, 8'(k + 1)); end
        end
    endtask

    task automatic test_loopback32();
        logic prev;
        int   cyc, rises, done_at, run, long_runs, max_run;
        if32.tx_word = 32'hDEADBEEF;
        if32.start = 1'b1;
        wait_cycle();
        cyc = 1;
        if32.start = 1'b0;
        checks++; if (if32.COPI !== 1'b1) begin fails++; $display("FAIL t32_copi0 got %b exp 1", if32.COPI); end
        rises = 0; done_at = 0; run = 0; long_runs = 0; max_run = 0; prev = 1'b0;
        while (cyc < Lat32 + 40) begin
            if (if32.SCK && !prev) begin
                rises++;
                if (run > ClkDiv) long_runs++;
                if (run > max_run) max_run = run;
            end
            run = (!if32.SCK && !if32.CS) ? run + 1 : 0;
            prev = if32.SCK;
            if (if32.done && done_at == 0) done_at = cyc;
            wait_cycle();
            cyc++;
        end
        checks++; if (if32.rx_word !== 32'hDEADBEEF) begin fails++; $display("FAIL t32_rx got %h exp deadbeef", if32.rx_word); end
        checks++; if (rises !== 32) begin fails++; $display("FAIL t32_sck_rises got %0d exp 32", rises); end
        checks++; if (done_at !== Lat32) begin fails++; $display("FAIL t32_latency got %0d exp %0d", done_at, Lat32); end
        checks++; if (long_runs !== LongRuns32) begin fails++; $display("FAIL t32_byte_gaps got %0d exp %0d", long_runs, LongRuns32); end
        checks++; if (max_run !== MaxRun32) begin fails++; $display("FAIL t32_max_low_run got %0d exp %0d", max_run, MaxRun32); end
    endtask

    task automatic test_back_to_back();
        int n, gap;
        if32.tx_word = 32'h0F1E2D3C;
        if32.start = 1'b1;
        wait_cycle();
        if32.tx_word = 32'h12345678;
        checks++; if (if32.busy !== 1'b1) begin fails++; $display("FAIL b2b_busy got %b exp 1", if32.busy); end
        n = 0;
        while (!if32.done && n < Lat32 + 40) begin wait_cycle(); n++; end
        checks++; if (if32.done !== 1'b1) begin fails++; $display("FAIL b2b_done1 got %b exp 1", if32.done); end
        checks++; if (if32.rx_word !== 32'h0F1E2D3C) begin fails++; $display("FAIL b2b_rx1 got %h exp 0f1e2d3c", if32.rx_word); end
        gap = 0;
        while (if32.CS && gap < 50) begin wait_cycle(); gap++; end
        if32.start = 1'b0;
        checks++; if (gap < ClkDiv) begin fails++; $display("FAIL b2b_cs_gap_min got %0d exp >= %0d", gap, ClkDiv); end
        checks++; if (gap > ClkDiv + 2) begin fails++; $display("FAIL b2b_cs_gap_max got %0d exp <= %0d", gap, ClkDiv + 2); end
        n = 0;
        while (!if32.done && n < Lat32 + 40) begin wait_cycle(); n++; end
        checks++; if (if32.rx_word !== 32'h12345678) begin fails++; $display("FAIL b2b_rx2 got %h exp 12345678", if32.rx_word); end
        repeat (3 * ClkDiv) wait_cycle();
        checks++; if (if32.busy !== 1'b0) begin fails++; $display("FAIL b2b_idle_busy got %b exp 0", if32.busy); end
        checks++; if (if32.CS !== 1'b1) begin fails++; $display("FAIL b2b_idle_cs got %b exp 1", if32.CS); end
    endtask

    task automatic test_reset_mid();
        logic prev;
        int   n, rises, done_cnt;
        if64.tx_word = 64'h1122334455667788;
        if64.start = 1'b1;
        wait_cycle();
        if64.start = 1'b0;
        rises = 0; n = 0; prev = 1'b0;
        while (rises < 14 && n < 400) begin
            if (if64.SCK && !prev) rises++;
            prev = if64.SCK;
            if (rises < 14) begin wait_cycle(); n++; end
        end
        checks++; if (if64.SCK !== 1'b1) begin fails++; $display("FAIL rmid_in_sck_hi got %b exp 1", if64.SCK); end
        resetn64 = 1'b0;
        wait_cycle();
        resetn64 = 1'b1;
        checks++; if (if64.CS !== 1'b1) begin fails++; $display("FAIL rmid_cs got %b exp 1", if64.CS); end
        checks++; if (if64.SCK !== 1'b0) begin fails++; $display("FAIL rmid_sck got %b exp 0", if64.SCK); end
        checks++; if (if64.busy !== 1'b0) begin fails++; $display("FAIL rmid_busy got %b exp 0", if64.busy); end
        checks++; if (if64.rx_word !== 64'h0) begin fails++; $display("FAIL rmid_rx got %h exp 0", if64.rx_word); end
        done_cnt = 0;
        for (int i = 0; i < Lat64 + 20; i++) begin
            if (if64.done) done_cnt++;
            wait_cycle();
        end
        checks++; if (done_cnt !== 0) begin fails++; $display("FAIL rmid_no_done got %0d exp 0", done_cnt); end
        // A fresh transfer must run from clean counters.
        test_transfer64();
    endtask

    task automatic test_protocol();
        checks++; if (viol !== 0) begin fails++; $display("FAIL protocol_violations got %0d exp 0", viol); end
    endtask

    initial begin
        test_reset();
        test_transfer64();
        test_loopback32();
        test_back_to_back();
        test_reset_mid();
        test_protocol();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end
endmodule
